// File: rtl/mmss_timer_pkg.sv
// Shared constants, select encodings and the run-state type for the mm:ss timer.
package mmss_timer_pkg;

    localparam int DIGIT_W      = 4;
    localparam int UNITS_MAX    = 9;
    localparam int SEC_TENS_MAX = 5;

    localparam logic [1:0] SEL_SEC_ONES = 2'b00;
    localparam logic [1:0] SEL_SEC_TENS = 2'b01;
    localparam logic [1:0] SEL_MIN_ONES = 2'b10;
    localparam logic [1:0] SEL_MIN_TENS = 2'b11;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] val,
                                                       input logic [DIGIT_W-1:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/mmss_timer_bcd_digit.sv
// One BCD display digit counting 0..MAX with inc/dec, clamped load and carry/borrow out.
module bcd_digit
    import mmss_timer_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               clk_c,
    input  logic               reset_n_c,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [DIGIT_W-1:0] val,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

    // Asserted on the step that rolls MAX->0 (up) or 0->MAX (down).
    assign carry = (inc && (q == MAX_V)) || (dec && (q == '0));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            q <= '0;
        end else if (load) begin
            q <= clamp_digit(val, MAX_V);
        end else if (inc) begin
            q <= (q == MAX_V) ? '0 : q + DIGIT_W'(1);
        end else if (dec) begin
            q <= (q == '0) ? MAX_V : q - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/mmss_timer.sv
// mm:ss up/down timer with BCD digits, prescaled tick and adjust mode.
// Optional lap display freeze is built when MMSS_TIMER_LAP_EN is defined.
module mmss_timer
    import mmss_timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5,
    parameter int TICK_DIV     = 1
) (
    input  logic               clk_c,
    input  logic               reset_n_c,
    input  logic               tick_c,
    input  logic               pause_c,
    input  logic               adj_c,
    input  logic [1:0]         sel_c,
    input  logic [3:0]         num_c,
    input  logic               load_c,
    input  logic               dir_c,
`ifdef MMSS_TIMER_LAP_EN
    input  logic               lap_c,
`endif
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               done,
    output logic               wrap
);

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    run_state_t         state_q, state_d;
    logic [7:0]         presc;
    logic               step, step_up, step_dn, expire, all_zero, load_acc;
    logic [DIGIT_W-1:0] so_q, st_q, mo_q, mt_q;
    logic               so_cy, st_cy, mo_cy, mt_cy;

    assign running  = (state_q == ST_RUN);
    assign load_acc = adj_c && load_c;
    assign all_zero = (so_q == '0) && (st_q == '0) && (mo_q == '0) && (mt_q == '0);
    assign step     = running && !adj_c && tick_c && (presc == TICK_LAST);
    assign step_up  = step && !dir_c;
    // A down step at 00:00 expires instead of borrowing, so the digits hold.
    assign step_dn  = step && dir_c && !all_zero;
    assign expire   = step && dir_c && all_zero;

    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            presc <= '0;
        end else if (!running) begin
            presc <= '0;
        end else if (tick_c && !adj_c) begin
            presc <= (presc == TICK_LAST) ? '0 : presc + 8'd1;
        end
    end

    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) state_q <= ST_STOP;
        else            state_q <= state_d;
    end

    // NOTE: assign every combinational output a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (!adj_c && pause_c) state_d = ST_RUN;
            ST_RUN:  if (adj_c || pause_c || expire) state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            wrap <= mt_cy && !dir_c;
            if (expire)                           done <= 1'b1;
            else if (pause_c || load_acc || adj_c) done <= 1'b0;
        end
    end

    bcd_digit #(.MAX(UNITS_MAX)) u_sec_ones (
        .clk_c, .reset_n_c, .inc(step_up), .dec(step_dn),
        .load(load_acc && (sel_c == SEL_SEC_ONES)), .val(num_c), .q(so_q), .carry(so_cy)
    );
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_c, .reset_n_c, .inc(so_cy && !dir_c), .dec(so_cy && dir_c),
        .load(load_acc && (sel_c == SEL_SEC_TENS)), .val(num_c), .q(st_q), .carry(st_cy)
    );
    bcd_digit #(.MAX(UNITS_MAX)) u_min_ones (
        .clk_c, .reset_n_c, .inc(st_cy && !dir_c), .dec(st_cy && dir_c),
        .load(load_acc && (sel_c == SEL_MIN_ONES)), .val(num_c), .q(mo_q), .carry(mo_cy)
    );
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk_c, .reset_n_c, .inc(mo_cy && !dir_c), .dec(mo_cy && dir_c),
        .load(load_acc && (sel_c == SEL_MIN_TENS)), .val(num_c), .q(mt_q), .carry(mt_cy)
    );

`ifdef MMSS_TIMER_LAP_EN
    logic               frozen;
    logic [DIGIT_W-1:0] snap_mt, snap_mo, snap_st, snap_so;

    // The live count keeps running underneath; only the displayed digits are held.
    always_ff @(posedge clk_c or negedge reset_n_c) begin
        if (!reset_n_c) begin
            frozen  <= 1'b0;
            snap_mt <= '0;
            snap_mo <= '0;
            snap_st <= '0;
            snap_so <= '0;
        end else if (adj_c) begin
            frozen <= 1'b0;
        end else if (lap_c) begin
            frozen <= !frozen;
            if (!frozen) begin
                snap_mt <= mt_q;
                snap_mo <= mo_q;
                snap_st <= st_q;
                snap_so <= so_q;
            end
        end
    end

    assign min_tens = frozen ? snap_mt : mt_q;
    assign min_ones = frozen ? snap_mo : mo_q;
    assign sec_tens = frozen ? snap_st : st_q;
    assign sec_ones = frozen ? snap_so : so_q;
`else
    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
`endif

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer: vector table, directed sequences and a
// randomized run against a seconds-based reference model (two parameter sets).
module tb_mmss_timer;

    typedef struct packed {
        logic       tick;
        logic       pause;
        logic       adj;
        logic [1:0] sel;
        logic [3:0] num;
        logic       load;
        logic       dir;
    } in_t;

    typedef struct {
        in_t         i;
        logic [18:0] exp;
    } vec_t;

    typedef struct {
        int secs;
        bit run;
        bit done;
        bit wrap;
        int pre;
    } mstate_t;

    logic clk_c = 1'b0;
    logic reset_n_c = 1'b0;
    logic tick_c = 0, pause_c = 0, adj_c = 0, load_c = 0, dir_c = 0;
    logic [1:0] sel_c = '0;
    logic [3:0] num_c = '0;
`ifdef MMSS_TIMER_LAP_EN
    logic lap_c = 1'b0;
`endif
    logic [3:0] mt1, mo1, st1, so1, mt2, mo2, st2, so2;
    logic run1, done1, wrap1, run2, done2, wrap2;

    int n_checks = 0;
    int n_pass = 0;
    mstate_t m1, m2;

    always #5 clk_c = ~clk_c;

    mmss_timer #(.MIN_TENS_MAX(5), .TICK_DIV(1)) dut (
        .clk_c(clk_c), .reset_n_c(reset_n_c), .tick_c(tick_c), .pause_c(pause_c),
        .adj_c(adj_c), .sel_c(sel_c), .num_c(num_c), .load_c(load_c), .dir_c(dir_c),
`ifdef MMSS_TIMER_LAP_EN
        .lap_c(lap_c),
`endif
        .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
        .running(run1), .done(done1), .wrap(wrap1)
    );

    mmss_timer #(.MIN_TENS_MAX(9), .TICK_DIV(3)) dut2 (
        .clk_c(clk_c), .reset_n_c(reset_n_c), .tick_c(tick_c), .pause_c(pause_c),
        .adj_c(adj_c), .sel_c(sel_c), .num_c(num_c), .load_c(load_c), .dir_c(dir_c),
`ifdef MMSS_TIMER_LAP_EN
        .lap_c(lap_c),
`endif
        .min_tens(mt2), .min_ones(mo2), .sec_tens(st2), .sec_ones(so2),
        .running(run2), .done(done2), .wrap(wrap2)
    );

    wire [18:0] word1 = {mt1, mo1, st1, so1, run1, done1, wrap1};
    wire [18:0] word2 = {mt2, mo2, st2, so2, run2, done2, wrap2};

    function automatic logic [18:0] e(int mt, int mo, int st, int so, bit r, bit d, bit w);
        return {4'(mt), 4'(mo), 4'(st), 4'(so), r, d, w};
    endfunction

    function automatic in_t mk(bit tick, bit pause, bit adj, int sel, int num, bit load, bit dir);
        in_t v;
        v.tick = tick; v.pause = pause; v.adj = adj; v.sel = 2'(sel);
        v.num = 4'(num); v.load = load; v.dir = dir;
        return v;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: the count is a plain number of seconds.
    function automatic mstate_t model_next(mstate_t s, in_t i, int mtm, int td);
        mstate_t n = s;
        int maxs = (mtm * 10 + 9) * 60 + 59;
        int mt, mo, st, so;
        bit step, expire;
        expire = 0;
        step = s.run && !i.adj && i.tick && (s.pre == td - 1);
        n.wrap = 0;
        if (step) begin
            if (!i.dir) begin
                if (s.secs == maxs) begin n.secs = 0; n.wrap = 1; end
                else n.secs = s.secs + 1;
            end else if (s.secs == 0) expire = 1;
            else n.secs = s.secs - 1;
        end
        if (i.adj && i.load) begin
            mt = s.secs / 600; mo = (s.secs / 60) % 10; st = (s.secs % 60) / 10; so = s.secs % 10;
            case (i.sel)
                2'd0: so = imin(int'(i.num), 9);
                2'd1: st = imin(int'(i.num), 5);
                2'd2: mo = imin(int'(i.num), 9);
                default: mt = imin(int'(i.num), mtm);
            endcase
            n.secs = mt * 600 + mo * 60 + st * 10 + so;
        end
        if (i.adj) n.run = 0;
        else if (expire) n.run = 0;
        else if (i.pause) n.run = !s.run;
        if (expire) n.done = 1;
        else if (i.pause || i.adj) n.done = 0;
        if (!s.run) n.pre = 0;
        else if (i.tick && !i.adj) n.pre = (s.pre == td - 1) ? 0 : s.pre + 1;
        return n;
    endfunction

    function automatic logic [18:0] pack(mstate_t s);
        return e(s.secs / 600, (s.secs / 60) % 10, (s.secs % 60) / 10, s.secs % 10,
                 s.run, s.done, s.wrap);
    endfunction

    function automatic mstate_t model_reset();
        mstate_t s;
        s.secs = 0; s.run = 0; s.done = 0; s.wrap = 0; s.pre = 0;
        return s;
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (mt mo st so run done wrap)", name, act, exp);
    endtask

    task automatic step_cycle(input in_t v);
        tick_c = v.tick; pause_c = v.pause; adj_c = v.adj; sel_c = v.sel;
        num_c = v.num; load_c = v.load; dir_c = v.dir;
        @(posedge clk_c);
        m1 = model_next(m1, v, 5, 1);
        m2 = model_next(m2, v, 9, 3);
        #1;
        tick_c = 0; pause_c = 0; load_c = 0;
    endtask

    task automatic do_reset(input string name);
        reset_n_c = 0;
        tick_c = 0; pause_c = 0; adj_c = 0; load_c = 0; dir_c = 0;
`ifdef MMSS_TIMER_LAP_EN
        lap_c = 0;
`endif
        #3;
        check(name, word1, e(0, 0, 0, 0, 0, 0, 0));
        m1 = model_reset();
        m2 = model_reset();
        repeat (2) @(posedge clk_c);
        @(negedge clk_c);
        reset_n_c = 1;
        step_cycle(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t vecs[$];
    in_t  rv;
    bit   r_adj, r_dir;

    initial begin
        vecs.push_back('{mk(0,0,1,3,7,1,0),  e(5,0,0,0,0,0,0)});
        vecs.push_back('{mk(0,0,1,2,12,1,0), e(5,9,0,0,0,0,0)});
        vecs.push_back('{mk(0,0,1,1,8,1,0),  e(5,9,5,0,0,0,0)});
        vecs.push_back('{mk(0,0,1,0,9,1,0),  e(5,9,5,9,0,0,0)});
        vecs.push_back('{mk(0,1,0,0,0,0,0),  e(5,9,5,9,1,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,0),  e(0,0,0,0,1,0,1)});
        vecs.push_back('{mk(0,0,0,0,0,0,0),  e(0,0,0,0,1,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,0),  e(0,0,0,1,1,0,0)});
        vecs.push_back('{mk(0,0,0,0,5,1,0),  e(0,0,0,1,1,0,0)});
        vecs.push_back('{mk(1,1,0,0,0,0,0),  e(0,0,0,2,0,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,0),  e(0,0,0,2,0,0,0)});
        vecs.push_back('{mk(0,1,0,0,0,0,1),  e(0,0,0,2,1,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,1),  e(0,0,0,1,1,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,1),  e(0,0,0,0,1,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,1),  e(0,0,0,0,0,1,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,1),  e(0,0,0,0,0,1,0)});
        vecs.push_back('{mk(0,1,0,0,0,0,1),  e(0,0,0,0,1,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,1),  e(0,0,0,0,0,1,0)});
        vecs.push_back('{mk(0,0,1,0,0,0,1),  e(0,0,0,0,0,0,0)});
        vecs.push_back('{mk(0,1,1,0,0,0,1),  e(0,0,0,0,0,0,0)});
        vecs.push_back('{mk(0,1,0,0,0,0,0),  e(0,0,0,0,1,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,0),  e(0,0,0,1,1,0,0)});
        vecs.push_back('{mk(1,0,1,0,0,0,0),  e(0,0,0,1,0,0,0)});
        vecs.push_back('{mk(1,0,0,0,0,0,0),  e(0,0,0,1,0,0,0)});

        do_reset("reset_initial");
        foreach (vecs[k]) begin
            step_cycle(vecs[k].i);
            check($sformatf("vec%0d", k), word1, vecs[k].exp);
        end

        // Sixty up-steps from zero reach one minute.
        do_reset("reset_before_count");
        step_cycle(mk(0, 1, 0, 0, 0, 0, 0));
        for (int n = 0; n < 60; n++) begin
            step_cycle(mk(1, 0, 0, 0, 0, 0, 0));
            if (n == 9) check("up_10s", word1, e(0, 0, 1, 0, 1, 0, 0));
        end
        check("up_60s", word1, e(0, 1, 0, 0, 1, 0, 0));

        // Asynchronous reset while counting clears everything before any edge.
        @(negedge clk_c);
        do_reset("reset_async_running");

        // Count down from 00:02 through expiry.
        step_cycle(mk(0, 0, 1, 0, 2, 1, 1));
        step_cycle(mk(0, 1, 0, 0, 0, 0, 1));
        step_cycle(mk(1, 0, 0, 0, 0, 0, 1));
        check("down_1", word1, e(0, 0, 0, 1, 1, 0, 0));
        step_cycle(mk(1, 0, 0, 0, 0, 0, 1));
        check("down_0", word1, e(0, 0, 0, 0, 1, 0, 0));
        step_cycle(mk(1, 0, 0, 0, 0, 0, 1));
        check("down_expire", word1, e(0, 0, 0, 0, 0, 1, 0));

`ifdef MMSS_TIMER_LAP_EN
        do_reset("reset_lap");
        step_cycle(mk(0, 1, 0, 0, 0, 0, 0));
        repeat (5) step_cycle(mk(1, 0, 0, 0, 0, 0, 0));
        lap_c = 1;
        step_cycle(mk(0, 0, 0, 0, 0, 0, 0));
        lap_c = 0;
        repeat (10) step_cycle(mk(1, 0, 0, 0, 0, 0, 0));
        check("lap_frozen", word1, e(0, 0, 0, 5, 1, 0, 0));
        lap_c = 1;
        step_cycle(mk(0, 0, 0, 0, 0, 0, 0));
        lap_c = 0;
        check("lap_release", word1, e(0, 0, 1, 5, 1, 0, 0));
`endif

        // Randomized run against the model for both parameter sets.
        do_reset("reset_random");
        r_adj = 0;
        r_dir = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(39) == 0) r_adj = !r_adj;
            if ($urandom_range(29) == 0) r_dir = !r_dir;
            rv.tick  = ($urandom_range(1) == 0);
            rv.pause = ($urandom_range(11) == 0);
            rv.adj   = r_adj;
            rv.sel   = 2'($urandom);
            rv.num   = 4'($urandom);
            rv.load  = ($urandom_range(3) == 0);
            rv.dir   = r_dir;
            step_cycle(rv);
            check($sformatf("rand_a_%0d", n), word1, pack(m1));
            check($sformatf("rand_b_%0d", n), word2, pack(m2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 Parameter MIN_TENS_MAX, default 5: maximum minute-tens value, range 5..9, so full scale is MIN_TENS_MAX9:59.
REQ-002 Parameter TICK_DIV, default 1: number of tick_c pulses per count step, range 1..255.
REQ-003 clk_c  in  1  single system clock.
REQ-004 reset_n_c  in  1  asynchronous active-low reset.
REQ-005 tick_c  in  1  one-cycle count-enable pulse, for example 1 Hz.
REQ-006 pause_c  in  1  one-cycle pulse that toggles run/stop; the pulse is pre-debounced.
REQ-007 adj_c  in  1  level; 1 = adjust mode.
REQ-008 sel_c  in  2  digit select: 00 sec_ones, 01 sec_tens, 10 min_ones, 11 min_tens.
REQ-009 num_c  in  4  value to load.
REQ-010 load_c  in  1  one-cycle strobe that writes num_c into the selected digit.
REQ-011 dir_c  in  1  count direction: 0 = up, 1 = down.
REQ-012 min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits, registered.
REQ-013 running  out  1  1 = counting.
REQ-014 done  out  1  down-count expired, sticky.
REQ-015 wrap  out  1  one-cycle pulse on up-count rollover.

Function
REQ-016 Step event = running && !adj_c && the TICK_DIV-th tick_c; the prescaler clears whenever running=0.
REQ-017 Digits update on the clk_c edge that samples the step event, with exactly one cycle of latency.
REQ-018 Up-count increments with BCD cascade: sec_ones 9->0 carries into sec_tens, sec_tens 5->0 into min_ones, and min_ones 9->0 into min_tens.
REQ-019 Up-count step at MIN_TENS_MAX9:59 SHALL give 00:00 with wrap=1 for one cycle, and running stays 1.
REQ-020 Down-count decrements with the mirror borrow chain.
REQ-021 Down-count step at 00:00 SHALL leave the digits at 00:00, clear running and set done.
REQ-022 pause_c with adj_c=0 toggles running; pause_c while adj_c=1 is ignored.
REQ-023 Starting a down-count at 00:00 is allowed: running is set, and done is asserted at the next step.
REQ-024 done clears on pause_c, on accepted load_c, on adj_c=1, or on reset.
REQ-025 adj_c=1 forces running=0 in the next cycle; leaving adjust leaves running=0.
REQ-026 load_c is accepted only when adj_c=1 and is ignored otherwise.
REQ-027 Load clamping:
- units digits: num_c>9 loads 9;
- sec_tens: num_c>5 loads 5;
- min_tens: num_c>MIN_TENS_MAX loads MIN_TENS_MAX.
REQ-028 When pause_c and a step event coincide, the step uses the pre-toggle running value and the toggle applies at the same edge.
REQ-029 dir_c is sampled per step; changing it mid-run takes effect at the next step with no glitch.
REQ-030 Digits never hold a non-BCD or out-of-range value.

Reset
REQ-031 reset_n_c low SHALL asynchronously set all digits to 0, running=0, done=0, wrap=0 and the prescaler to 0.
REQ-032 Release of reset_n_c is synchronous to clk_c.
REQ-033 Reset during counting or adjusting discards all state, with no partial update.

Configuration
REQ-034 Macro MMSS_TIMER_LAP_EN, when defined, adds input lap_c (1 bit, one-cycle pulse).
REQ-035 With MMSS_TIMER_LAP_EN, each lap_c pulse toggles a display freeze:
- while frozen, the outputs hold the snapshot taken at the lap_c edge and the internal count continues;
- the next lap_c pulse, reset, or adj_c=1 unfreezes the display.
REQ-036 Without MMSS_TIMER_LAP_EN, the lap_c port and the freeze logic are absent, and the outputs always show the live count.

Structure
REQ-037 Package mmss_timer_pkg SHALL hold DIGIT_W=4, UNITS_MAX=9, SEC_TENS_MAX=5, and SEL encodings SEL_SEC_ONES, SEL_SEC_TENS, SEL_MIN_ONES, SEL_MIN_TENS.
REQ-038 Sub-module bcd_digit SHALL provide:
- parameter MAX, inputs inc, dec, load and val;
- outputs q and carry/borrow, where carry/borrow is asserted at MAX->0 or 0->MAX;
- load clamping internal to the sub-module;
- instantiated four times.

Verification
REQ-039 Reset, then pause_c, then 60 steps up with TICK_DIV=1 -> 01:00 with running=1.
REQ-040 adj_c=1 with sel_c=11, num_c=7, load_c, and MIN_TENS_MAX=5 -> min_tens=5 and running=0.
REQ-041 Preload 59:59, up, one step -> 00:00, wrap high for exactly one cycle.
REQ-042 Preload 00:02, dir_c=1, run 3 steps -> 00:01, 00:00, then done=1, running=0, digits hold 00:00.
REQ-043 pause_c coincident with a step while running -> that step counts and running=0 afterward; load_c with adj_c=0 -> no change.
REQ-044 Build with MMSS_TIMER_LAP_EN, lap_c at 00:05, then 10 steps -> outputs hold 00:05; second lap_c -> 00:15.
